// File: rtl/score_keeper.sv
// Two-digit BCD score / best-score tracker driving the tens and units SSD nibbles.
// Input rises reach the registered outputs SYNC_STAGES+1 board_clk edges after the level changes.
module score_keeper #(
    parameter int SYNC_STAGES = 2,
    parameter int ALT_BITS    = 26
) (
    input  logic       board_clk,
    input  logic       Reset,
    input  logic       score_in,
    input  logic       lose_in,
    input  logic       start_in,
    input  logic       ack_in,
    output logic [3:0] ssd3,
    output logic [3:0] ssd0,
    output logic [7:0] score_bcd,
    output logic [7:0] best_bcd,
    output logic       game_over,
    output logic       new_best,
    output logic       showing_best
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    // Bit order inside the synchronizer vectors: {ack, start, lose, score}
    localparam int B_SCORE = 0;
    localparam int B_LOSE  = 1;
    localparam int B_START = 2;
    localparam int B_ACK   = 3;

    logic [3:0]          r_sync [SYNC_STAGES];
    logic [3:0]          r_prev;
    logic [3:0]          w_in;
    logic [3:0]          w_rise;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_score;
    logic [7:0]          w_score_nxt;
    logic [7:0]          w_score_inc;
    logic [7:0]          r_best;
    logic [7:0]          w_best_nxt;
    logic                r_new_best;
    logic                w_new_best_nxt;
    logic [ALT_BITS-1:0] r_alt;
    logic [ALT_BITS-1:0] w_alt_nxt;
    logic                r_game_over;
    logic                r_showing_best;
    logic                w_showing_best_nxt;
    logic [7:0]          w_disp_nxt;
    logic [3:0]          r_ssd3;
    logic [3:0]          r_ssd0;

    assign w_in   = {ack_in, start_in, lose_in, score_in};
    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= '0;
            end
            r_prev <= '0;
        end else begin
            r_sync[0] <= w_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    // Saturating BCD increment; 99 stays 99.
    always_comb begin
        w_score_inc = r_score;
        if (r_score != 8'h99) begin
            if (r_score[3:0] == 4'd9) begin
                w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
            end else begin
                w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
            end
        end
    end

    assign w_alt_nxt = r_alt + {{(ALT_BITS-1){1'b0}}, 1'b1};

    always_comb begin
        w_state_nxt    = r_state;
        w_score_nxt    = r_score;
        w_best_nxt     = r_best;
        w_new_best_nxt = r_new_best;
        case (r_state)
            IDLE: begin
                if (w_rise[B_START]) begin
                    w_state_nxt    = PLAY;
                    w_score_nxt    = 8'h00;
                    w_new_best_nxt = 1'b0;
                end
            end
            PLAY: begin
                if (w_rise[B_SCORE]) begin
                    w_score_nxt = w_score_inc;
                end
                // The compare sees the score including any same-cycle increment.
                if (w_rise[B_LOSE]) begin
                    w_state_nxt = OVER;
                    if (w_score_nxt > r_best) begin
                        w_best_nxt     = w_score_nxt;
                        w_new_best_nxt = 1'b1;
                    end else begin
                        w_new_best_nxt = 1'b0;
                    end
                end
            end
            OVER: begin
                if (w_rise[B_ACK]) begin
                    w_state_nxt    = IDLE;
                    w_new_best_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Display is derived from next-state values so it lands on the same edge as the state.
    always_comb begin
        w_showing_best_nxt = 1'b0;
        case (w_state_nxt)
            IDLE:    w_showing_best_nxt = 1'b1;
            OVER:    w_showing_best_nxt = w_alt_nxt[ALT_BITS-1];
            default: w_showing_best_nxt = 1'b0;
        endcase
        w_disp_nxt = w_showing_best_nxt ? w_best_nxt : w_score_nxt;
    end

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_state        <= IDLE;
            r_score        <= 8'h00;
            r_best         <= 8'h00;
            r_new_best     <= 1'b0;
            r_alt          <= '0;
            r_game_over    <= 1'b0;
            r_showing_best <= 1'b1;
            r_ssd3         <= 4'h0;
            r_ssd0         <= 4'h0;
        end else begin
            r_state        <= w_state_nxt;
            r_score        <= w_score_nxt;
            r_best         <= w_best_nxt;
            r_new_best     <= w_new_best_nxt;
            r_alt          <= w_alt_nxt;
            r_game_over    <= (w_state_nxt == OVER);
            r_showing_best <= w_showing_best_nxt;
            r_ssd3         <= w_disp_nxt[7:4];
            r_ssd0         <= w_disp_nxt[3:0];
        end
    end

    assign ssd3         = r_ssd3;
    assign ssd0         = r_ssd0;
    assign score_bcd    = r_score;
    assign best_bcd     = r_best;
    assign game_over    = r_game_over;
    assign new_best     = r_new_best;
    assign showing_best = r_showing_best;

endmodule
